// File: rtl/canvas_pkg.sv
// canvas_pkg: canvas geometry, cell-grid sizing and cell writer state encoding.
package canvas_pkg;
    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int CELL_SHIFT = 3;
    localparam int COLS       = H_RES >> CELL_SHIFT;
    localparam int ROWS       = V_RES >> CELL_SHIFT;
    localparam int CELLS      = COLS * ROWS;
    localparam int ADDR_W     = 13;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, CLR} canvas_wr_state_t;
endpackage

// File: rtl/canvas_coord_map.sv
// canvas_coord_map: pixel position to cell address, with on-screen range flag.
module canvas_coord_map
    import canvas_pkg::*;
(
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);
    assign valid = (x < 10'(H_RES)) && (y < 9'(V_RES));
    assign addr  = ADDR_W'(y >> CELL_SHIFT) * ADDR_W'(COLS) + ADDR_W'(x >> CELL_SHIFT);
endmodule

// File: rtl/canvas_cell_writer.sv
// canvas_cell_writer: toggles a drawn cell by read-modify-write, or sweeps the
// whole grid to 0, through a req/gnt RAM port shared with the life engine.
module canvas_cell_writer
    import canvas_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              drawPixel,
    input  logic              clearCanvas,
    input  logic [9:0]        drawX,
    input  logic [8:0]        drawY,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic              busy,
    output logic              draw_done,
    output logic              clear_done,
    output logic              dropped
);
    canvas_wr_state_t  state;
    logic [ADDR_W-1:0] in_addr, pend_addr;
    logic              in_valid, draw_pend, clear_pend, take, clr_req;

    canvas_coord_map u_map (.x(drawX), .y(drawY), .addr(in_addr), .valid(in_valid));

    assign take    = drawPixel && in_valid;
    assign clr_req = clear_pend || clearCanvas;

    // mem_addr doubles as the sweep counter while in CLR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 1'b0;
            busy       <= 1'b0;
            draw_done  <= 1'b0;
            clear_done <= 1'b0;
            dropped    <= 1'b0;
            draw_pend  <= 1'b0;
            clear_pend <= 1'b0;
            pend_addr  <= '0;
        end else begin
            draw_done  <= 1'b0;
            clear_done <= 1'b0;
            dropped    <= drawPixel && !in_valid;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state      <= CLR;
                        busy       <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_wdata  <= 1'b0;
                        mem_addr   <= '0;
                        clear_pend <= 1'b0;
                        draw_pend  <= 1'b0;
                        if (take || draw_pend) dropped <= 1'b1;
                    end else if (draw_pend || take) begin
                        state     <= RD_REQ;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= draw_pend ? pend_addr : in_addr;
                        draw_pend <= draw_pend && take;
                        pend_addr <= in_addr;
                    end
                end
                RD_REQ: if (mem_gnt) begin
                    state   <= RD_WAIT;
                    mem_req <= 1'b0;
                end
                RD_WAIT: begin
                    state     <= WR_REQ;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= ~mem_rdata;
                end
                WR_REQ: if (mem_gnt) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_req   <= 1'b0;
                    draw_done <= 1'b1;
                end
                CLR: if (mem_gnt) begin
                    if (mem_addr == ADDR_W'(CELLS - 1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        mem_req    <= 1'b0;
                        mem_addr   <= '0;
                        clear_done <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // while busy: a clear request outranks any queued draw
            if (state == CLR) begin
                if (take) begin
                    if (draw_pend) dropped <= 1'b1;
                    else begin
                        draw_pend <= 1'b1;
                        pend_addr <= in_addr;
                    end
                end
            end else if (state != IDLE) begin
                if (clr_req) begin
                    clear_pend <= 1'b1;
                    draw_pend  <= 1'b0;
                    if (draw_pend || take) dropped <= 1'b1;
                end else if (take) begin
                    if (draw_pend) dropped <= 1'b1;
                    else begin
                        draw_pend <= 1'b1;
                        pend_addr <= in_addr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_canvas_cell_writer.sv
// tb_canvas_cell_writer: directed scoreboard bench for the canvas cell writer.
module tb_canvas_cell_writer;
    localparam int NCELL = 4800;

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic        wdata;
    } xfer_t;

    logic        clk = 0, rst = 0, drawPixel = 0, clearCanvas = 0, gnt = 1, rdata = 0;
    logic [9:0]  drawX = 0;
    logic [8:0]  drawY = 0;
    logic        mem_req, mem_we, mem_wdata, busy, draw_done, clear_done, dropped;
    logic [12:0] mem_addr;

    int    errors = 0, checks = 0, cyc = 0;
    int    n_dd = 0, n_cd = 0, n_drop = 0, n_stall = 0, n_xfer = 0;
    int    dd_cyc = 0, cd_cyc = 0, last_cyc = 0;
    bit    sb_on = 1;
    bit    cells  [NCELL];
    bit    shadow [NCELL];
    xfer_t q[$];

    canvas_cell_writer dut (
        .clk(clk), .rst(rst), .drawPixel(drawPixel), .clearCanvas(clearCanvas),
        .drawX(drawX), .drawY(drawY), .mem_req(mem_req), .mem_gnt(gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata), .busy(busy),
        .draw_done(draw_done), .clear_done(clear_done), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_draw(input int x, input int y);
        int a;
        xfer_t t;
        a = (y / 8) * 80 + (x / 8);
        t.we = 0; t.addr = 13'(a); t.wdata = 0;
        q.push_back(t);
        t.we = 1; t.wdata = ~shadow[a];
        q.push_back(t);
        shadow[a] = ~shadow[a];
    endtask

    task automatic exp_clear();
        xfer_t t;
        for (int i = 0; i < NCELL; i++) begin
            t.we = 1; t.addr = 13'(i); t.wdata = 0;
            q.push_back(t);
            shadow[i] = 0;
        end
    endtask

    task automatic draw(input int x, input int y);
        drawX = 10'(x); drawY = 9'(y); drawPixel = 1;
        tick();
        drawPixel = 0;
    endtask

    task automatic clear();
        clearCanvas = 1;
        tick();
        clearCanvas = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || q.size() != 0) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", k < 20000, 1);
        tick(3);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: RAM model, scoreboard pops, stall stability and pulse counters
    initial begin
        bit          stalled = 0;
        logic        p_we, p_wd;
        logic [12:0] p_addr;
        xfer_t       t;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 0;
                continue;
            end
            if (draw_done) begin n_dd++; dd_cyc = cyc; end
            if (clear_done) begin n_cd++; cd_cyc = cyc; end
            if (dropped) n_drop++;
            if (stalled && mem_req) begin
                chk("stall_we", mem_we, p_we);
                chk("stall_addr", mem_addr, p_addr);
                chk("stall_wdata", mem_wdata, p_wd);
            end
            stalled = mem_req && !gnt;
            p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
            if (stalled) n_stall++;
            if (mem_req && gnt) begin
                n_xfer++;
                if (mem_we) cells[mem_addr] = mem_wdata;
                else rdata = cells[mem_addr];
                if (mem_we && mem_addr == 13'(NCELL - 1)) last_cyc = cyc;
                if (sb_on) begin
                    if (q.size() == 0) chk("unexpected_xfer", mem_addr, 32'hFFFF);
                    else begin
                        t = q.pop_front();
                        chk("xfer_we", mem_we, t.we);
                        chk("xfer_addr", mem_addr, t.addr);
                        if (t.we) chk("xfer_wdata", mem_wdata, t.wdata);
                    end
                end
            end
        end
    end

    initial begin
        int c0, dd0, cd0, dr0, st0, x0;
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {draw_done, clear_done, dropped}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we_wd", {mem_we, mem_wdata}, 0);
        tick(2);
        rst = 1;
        tick(2);

        // basic toggle with latency
        exp_draw(17, 9);
        c0 = cyc;
        draw(17, 9);
        wait_idle();
        chk("lat_done", dd_cyc - c0, 4);
        chk("cell82", cells[82], 1);

        // corner cell, then off-screen requests
        exp_draw(639, 479);
        draw(639, 479);
        wait_idle();
        chk("cell4799", cells[4799], 1);
        dr0 = n_drop; x0 = n_xfer;
        draw(640, 0);
        wait_idle();
        chk("drop_x", n_drop - dr0, 1);
        draw(0, 480);
        wait_idle();
        chk("drop_y", n_drop - dr0, 2);
        chk("drop_noreq", n_xfer - x0, 0);

        // 5-cycle stalls on read and write
        exp_draw(17, 9);
        dd0 = n_dd; st0 = n_stall;
        gnt = 0;
        c0 = cyc;
        draw(17, 9);
        for (int k = 1; k < 14; k++) begin
            gnt = (cyc == c0 + 6) || (cyc == c0 + 13);
            tick();
        end
        gnt = 1;
        wait_idle();
        chk("stall_lat", dd_cyc - c0, 14);
        chk("stall_cycles", n_stall - st0, 10);
        chk("stall_cell", cells[82], 0);

        // three back-to-back draws: one runs, one queued, one dropped
        exp_draw(0, 0);
        exp_draw(8, 0);
        dd0 = n_dd; dr0 = n_drop;
        drawPixel = 1; drawY = 0; drawX = 0;
        tick();
        drawX = 8;
        tick();
        drawX = 16;
        tick();
        drawPixel = 0; drawX = 100;
        wait_idle();
        chk("b2b_done", n_dd - dd0, 2);
        chk("b2b_drop", n_drop - dr0, 1);
        chk("b2b_cell2", cells[2], 0);

        // plain sweep with coalesced clear and a draw held until after it
        exp_clear();
        exp_draw(17, 9);
        dd0 = n_dd; cd0 = n_cd; dr0 = n_drop;
        clear();
        tick(100);
        clear();
        tick(10);
        draw(17, 9);
        wait_idle();
        chk("clr_done", n_cd - cd0, 1);
        chk("clr_done_lat", cd_cyc - last_cyc, 1);
        chk("clr_nodrop", n_drop - dr0, 0);
        chk("clr_held_draw", n_dd - dd0, 1);
        chk("clr_draw_after", dd_cyc > cd_cyc, 1);

        // clear in RD_WAIT with a draw queued
        exp_draw(24, 0);
        exp_clear();
        dd0 = n_dd; cd0 = n_cd; dr0 = n_drop;
        drawPixel = 1; drawX = 24; drawY = 0;
        tick();
        drawX = 32;
        tick();
        drawPixel = 0; clearCanvas = 1;
        tick();
        clearCanvas = 0;
        wait_idle();
        chk("rmw_clr_done", n_dd - dd0, 1);
        chk("rmw_clr_drop", n_drop - dr0, 1);
        chk("rmw_clr_cd", n_cd - cd0, 1);

        // draw and clear together in IDLE
        exp_clear();
        dd0 = n_dd; cd0 = n_cd; dr0 = n_drop;
        drawPixel = 1; clearCanvas = 1; drawX = 17; drawY = 9;
        tick();
        drawPixel = 0; clearCanvas = 0;
        wait_idle();
        chk("same_drop", n_drop - dr0, 1);
        chk("same_nodraw", n_dd - dd0, 0);
        chk("same_cd", n_cd - cd0, 1);

        // reset mid-sweep, then restart from address 0
        sb_on = 0;
        clear();
        tick(50);
        #2 rst = 0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_busy", busy, 0);
        tick(2);
        rst = 1;
        tick(2);
        q.delete();
        sb_on = 1;
        exp_clear();
        cd0 = n_cd;
        clear();
        wait_idle();
        chk("restart_cd", n_cd - cd0, 1);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/canvas_cell_writer.md
Name: canvas_cell_writer

Overview:
Memory-side responder for the drawing controller's pixel-draw and canvas-clear pulses. It maps a pixel cursor position to a Game-of-Life cell address. A draw pulse toggles that cell with a read-modify-write; a clear pulse sweeps every cell to 0. It owns one port of the cell-grid RAM through a req/gnt handshake that is arbitrated against the life engine.

Parameters:
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- CELL_SHIFT, 3, log2 of the cell edge in pixels (8x8 cells, giving an 80x60 grid).
- ADDR_W, 13, cell address width; must satisfy 2^ADDR_W >= (H_RES>>CELL_SHIFT)*(V_RES>>CELL_SHIFT).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- drawPixel  in  1  one-cycle draw request.
- clearCanvas  in  1  one-cycle clear request.
- drawX  in  10  pixel X, sampled with drawPixel.
- drawY  in  9  pixel Y, sampled with drawPixel.
- mem_req  out  1  RAM access request.
- mem_gnt  in  1  grant; a transfer occurs on a clock edge where mem_req && mem_gnt.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  cell address.
- mem_wdata  out  1  write data.
- mem_rdata  in  1  read data, valid the cycle after a read transfer.
- busy  out  1  high in any state other than IDLE.
- draw_done  out  1  one-cycle pulse when a toggle completes.
- clear_done  out  1  one-cycle pulse when a sweep completes.
- dropped  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Reset (rst=0): state=IDLE. All outputs 0. Pending flags cleared. Sweep counter 0.
- Address: col=drawX>>CELL_SHIFT, row=drawY>>CELL_SHIFT, addr=row*COLS+col. The multiply is computed at ADDR_W width with no truncation.
- Range check: drawX>=H_RES or drawY>=V_RES means the request is ignored and dropped pulses the next cycle.
- Coordinates are captured into registers on drawPixel acceptance. Later drawX/drawY changes have no effect on an accepted request.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, CLR.
  - IDLE: a pending clear or clearCanvas goes to CLR. Else a pending draw or valid drawPixel goes to RD_REQ.
  - RD_REQ: mem_req=1, mem_we=0, addr held. On gnt go to RD_WAIT.
  - RD_WAIT: capture mem_rdata, go to WR_REQ.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata=~captured bit. On gnt go to IDLE and pulse draw_done the following cycle.
  - CLR: mem_req=1, mem_we=1, mem_wdata=0, mem_addr=sweep counter. Each granted transfer increments the counter. The transfer at CELLS-1 resets the counter to 0, returns to IDLE, and pulses clear_done the next cycle.
- mem_req/mem_we/mem_addr/mem_wdata stay stable while mem_req=1 and gnt=0, for any number of stall cycles.
- Latency with gnt tied 1: drawPixel at cycle 0, read transfer at cycle 1, write transfer at cycle 3, draw_done at cycle 4.
- drawPixel while busy: stored in a one-deep pending draw (coords latched).
  - If the pending slot is already full, the new request is discarded and dropped pulses.
- clearCanvas while drawing: sets clear_pending. The current RMW finishes, then the clear runs. Any pending draw is discarded with a dropped pulse.
- clearCanvas while in CLR: coalesced. No restart, no dropped pulse.
- drawPixel while in CLR: held pending and executed after clear_done.
- drawPixel and clearCanvas in the same IDLE cycle: the clear wins and the draw is dropped.
- Reset mid-operation: immediate return to IDLE and mem_req=0. A partial sweep is not resumed.

Decomposition:
- Package canvas_pkg:
  - H_RES, V_RES, CELL_SHIFT.
  - Derived COLS=H_RES>>CELL_SHIFT, ROWS=V_RES>>CELL_SHIFT, CELLS=COLS*ROWS, ADDR_W.
  - Enum canvas_wr_state_t.
- Sub-module canvas_coord_map: pure pixel-to-address plus range-valid logic, reused by the display scanout.

Test Plan:
- gnt=1, drawPixel with (17,9) -> read then write at addr 82. If rdata=0, wdata=1. draw_done at cycle 4.
- drawPixel with (639,479) -> addr 4799. drawPixel with (640,0) -> no mem_req, dropped pulses once.
- clearCanvas with gnt=1 -> 4800 writes, wdata=0, addr 0..4799 in order. clear_done one cycle after addr 4799.
- gnt held 0 for 5 cycles during RD_REQ and WR_REQ -> req/addr/we stable. Completion is delayed by exactly 10 cycles.
- Three drawPixel pulses on consecutive cycles -> first executes, second executes afterward, third causes dropped. Exactly two draw_done pulses.
- clearCanvas during RD_WAIT with a draw pending -> toggle completes, pending draw dropped, then full sweep.
- Reset asserted mid-sweep -> mem_req=0 asynchronously; restarting a clear starts again at addr 0.
